// File: rtl/audio_pkg.sv
// Shared types and constants for the microphone-to-FFT audio path.
package audio_pkg;

  localparam int FFT_LEN  = 512;
  localparam int WIDTH    = 16;
  localparam int NUM_MICS = 4;
  localparam int TDATA_W  = NUM_MICS * 2 * WIDTH;

  typedef logic signed [WIDTH-1:0] sample_t;
  typedef sample_t [NUM_MICS-1:0] mic_frame_t;

  // Each channel becomes one complex word: real part high, imaginary part zero.
  function automatic logic [TDATA_W-1:0] pack_fft_tdata(mic_frame_t m);
    logic [TDATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < NUM_MICS; i++) begin
      d[i*2*WIDTH + WIDTH +: WIDTH] = m[i];
    end
    return d;
  endfunction

endpackage

// File: rtl/frame_windower_if.sv
// AXI-stream link from the windower to the FFT core's slave port.
interface frame_windower_if;
  import audio_pkg::*;

  logic [TDATA_W-1:0] tdata;
  logic               tvalid;
  logic               tlast;
  logic               tready;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);

endinterface

// File: rtl/window_rom.sv
// Hann window coefficient ROM, Q0.15 stored in 16 bits, registered read.
module window_rom #(
  parameter int    FFT_LEN     = 512,
  parameter int    WIDTH       = 16,
  parameter string WINDOW_FILE = "hann_512.mem",
  localparam int   AW          = $clog2(FFT_LEN)
) (
  input  logic             clk_in,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] mem [FFT_LEN];

  initial begin
    for (int n = 0; n < FFT_LEN; n++) begin
      mem[n] = WIDTH'($rtoi(32767.5 * (1.0 - $cos(2.0 * 3.141592653589793 * real'(n) / real'(FFT_LEN))) + 0.5) >> 1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (en) data <= mem[addr];
  end

endmodule

// File: rtl/frame_windower.sv
// Frames 4-channel PCM into FFT_LEN-sample blocks, applies a Hann window and
// streams zero-imaginary complex beats to the FFT with tlast on the frame end.
module frame_windower #(
  parameter int    FFT_LEN     = audio_pkg::FFT_LEN,
  parameter int    WIDTH       = audio_pkg::WIDTH,
  parameter string WINDOW_FILE = "hann_512.mem",
  localparam int   IDX_W       = $clog2(FFT_LEN)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  audio_pkg::mic_frame_t audio_data_in,
  input  logic                  audio_valid_in,
  output logic                  audio_ready_out,
  input  logic                  window_en_in,
  frame_windower_if.master      m_axis,
  output logic [15:0]           drop_count_out,
  output logic [IDX_W-1:0]      frame_index_out
);
  import audio_pkg::*;

  localparam int COEF_W = WIDTH + 1;
  localparam int PROD_W = WIDTH + COEF_W + 1;
  localparam logic [COEF_W-1:0] UNITY = COEF_W'(1) << (WIDTH - 1);

  // Round-half-up Q.15 scaling; |c| <= 2^15 keeps the result inside 16 bits.
  function automatic sample_t win_scale(sample_t s, logic [COEF_W-1:0] c);
    logic signed [PROD_W-1:0] p;
    p = PROD_W'(s) * PROD_W'($signed({1'b0, c}));
    p = p + (PROD_W'(1) <<< (WIDTH - 2));
    return sample_t'(p >>> (WIDTH - 1));
  endfunction

  logic               en, accept, mode_now;
  logic [IDX_W-1:0]   idx_q;
  logic               mode_q;
  logic [15:0]        drop_q;
  logic               vld_p0, vld_p1, vld_p2;
  mic_frame_t         smp_p0, smp_p1, scaled_p1;
  logic [IDX_W-1:0]   idx_p0;
  logic               mode_p0, mode_p1, last_p1;
  logic [WIDTH-1:0]   rom_p1;
  logic [COEF_W-1:0]  coef_p1;
  logic [TDATA_W-1:0] tdata_p2;
  logic               tlast_p2;

  assign en              = !vld_p2 || m_axis.tready;
  assign audio_ready_out = en;
  assign accept          = audio_valid_in && en;
  assign mode_now        = (idx_q == '0) ? window_en_in : mode_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      idx_q    <= '0;
      mode_q   <= 1'b1;
      drop_q   <= '0;
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      tlast_p2 <= 1'b0;
      tdata_p2 <= '0;
    end else begin
      if (accept) begin
        idx_q  <= idx_q + 1'b1;
        mode_q <= mode_now;
      end
      if (audio_valid_in && !en && drop_q != '1) drop_q <= drop_q + 1'b1;
      if (en) begin
        vld_p0   <= accept;
        vld_p1   <= vld_p0;
        vld_p2   <= vld_p1;
        tlast_p2 <= vld_p1 && last_p1;
        if (vld_p1) tdata_p2 <= pack_fft_tdata(scaled_p1);
      end
    end
  end

  // p0: accepted samples; p1: ROM coefficient arrives alongside the samples
  always_ff @(posedge clk_in) begin
    if (accept) begin
      smp_p0  <= audio_data_in;
      idx_p0  <= idx_q;
      mode_p0 <= mode_now;
    end
    if (en) begin
      smp_p1  <= smp_p0;
      mode_p1 <= mode_p0;
      last_p1 <= (idx_p0 == IDX_W'(FFT_LEN - 1));
    end
  end

  window_rom #(
    .FFT_LEN     (FFT_LEN),
    .WIDTH       (WIDTH),
    .WINDOW_FILE (WINDOW_FILE)
  ) u_rom (
    .clk_in (clk_in),
    .en     (en),
    .addr   (idx_p0),
    .data   (rom_p1)
  );

  // p1 -> p2: multiply-round feeding the output register
  always_comb begin
    coef_p1 = mode_p1 ? {1'b0, rom_p1} : UNITY;
    for (int ch = 0; ch < NUM_MICS; ch++) begin
      scaled_p1[ch] = win_scale(smp_p1[ch], coef_p1);
    end
  end

  assign m_axis.tdata    = tdata_p2;
  assign m_axis.tvalid   = vld_p2;
  assign m_axis.tlast    = tlast_p2;
  assign drop_count_out  = drop_q;
  assign frame_index_out = idx_q;

endmodule

// File: tb/tb_frame_windower.sv
// Scoreboard bench for frame_windower: windowing, bypass, stalls, resets, random traffic.
module tb_frame_windower;
  import audio_pkg::*;

  localparam int  N  = 512;
  localparam real PI = 3.141592653589793;

  typedef struct packed { logic [127:0] d; logic l; } beat_t;

  logic       clk_in         = 1'b0;
  logic       rst_in         = 1'b1;
  mic_frame_t audio_data_in  = '0;
  logic       audio_valid_in = 1'b0;
  logic       audio_ready_out;
  logic       window_en_in   = 1'b1;
  logic [15:0] drop_count_out;
  logic [8:0]  frame_index_out;

  frame_windower_if axis ();

  frame_windower #(.FFT_LEN(N), .WIDTH(16), .WINDOW_FILE("")) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .audio_data_in   (audio_data_in),
    .audio_valid_in  (audio_valid_in),
    .audio_ready_out (audio_ready_out),
    .window_en_in    (window_en_in),
    .m_axis          (axis),
    .drop_count_out  (drop_count_out),
    .frame_index_out (frame_index_out)
  );

  always #5 clk_in = ~clk_in;

  int    win [N];
  beat_t sb [$];
  beat_t log_q [$];
  beat_t exp_b;
  int    total = 0;
  int    bad   = 0;
  int    m_idx = 0;
  int    m_drop = 0;
  int    m_acc = 0;
  logic  m_mode = 1'b1;
  logic [127:0] w1000;

  function automatic beat_t model_beat(mic_frame_t s, int idx, logic mode);
    beat_t  b;
    longint c, p, r;
    c   = mode ? longint'(win[idx]) : 32768;
    b.d = '0;
    for (int ch = 0; ch < 4; ch++) begin
      p = longint'(s[ch]) * c;
      r = (p + 16384) >>> 15;
      b.d[ch*32+16 +: 16] = r[15:0];
    end
    b.l = (idx == N - 1);
    return b;
  endfunction

  function automatic mic_frame_t fill(int v);
    mic_frame_t f;
    for (int c = 0; c < 4; c++) f[c] = sample_t'(v);
    return f;
  endfunction

  function automatic mic_frame_t rand_frame();
    mic_frame_t f;
    for (int c = 0; c < 4; c++) f[c] = sample_t'($urandom);
    return f;
  endfunction

  // Reference model and output scoreboard, evaluated mid-cycle
  always @(negedge clk_in) begin
    if (rst_in) begin
      if (audio_valid_in && audio_ready_out) begin
        if (m_idx == 0) m_mode = window_en_in;
        sb.push_back(model_beat(audio_data_in, m_idx, m_mode));
        m_idx = (m_idx + 1) % N;
        m_acc++;
      end else if (audio_valid_in && m_drop < 65535) begin
        m_drop++;
      end
      if (axis.tvalid && axis.tready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_underflow: unexpected beat tdata=%h tlast=%b, want no beat", axis.tdata, axis.tlast);
        end else begin
          exp_b = sb.pop_front();
          if (axis.tdata !== exp_b.d || axis.tlast !== exp_b.l) begin
            bad++;
            $display("FAIL sb_beat: got tdata=%h tlast=%b, want tdata=%h tlast=%b", axis.tdata, axis.tlast, exp_b.d, exp_b.l);
          end
        end
        log_q.push_back('{axis.tdata, axis.tlast});
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic model_reset();
    sb.delete();
    m_idx  = 0;
    m_mode = 1'b1;
    m_drop = 0;
  endtask

  task automatic send(input mic_frame_t s);
    audio_data_in  = s;
    audio_valid_in = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk_in);
      if (audio_ready_out) begin
        tick();
        return;
      end
      tick();
    end
    total++;
    bad++;
    $display("FAIL send_timeout: audio_ready_out=0 for 200 cycles, want 1");
  endtask

  task automatic drain();
    audio_valid_in = 1'b0;
    axis.tready    = 1'b1;
    for (int t = 0; t < 64 && (sb.size() != 0 || axis.tvalid); t++) tick();
    total++;
    if (sb.size() != 0 || axis.tvalid !== 1'b0) begin
      bad++;
      $display("FAIL drain: pending=%0d tvalid=%b, want 0 and 0", sb.size(), axis.tvalid);
    end
  endtask

  task automatic test_reset();
    axis.tready    = 1'b1;
    audio_valid_in = 1'b0;
    #1 rst_in = 1'b0;
    repeat (3) tick();
    total++;
    if (axis.tvalid !== 1'b0 || axis.tlast !== 1'b0) begin
      bad++; $display("FAIL rst_ctrl: tvalid=%b tlast=%b, want 0 0", axis.tvalid, axis.tlast);
    end
    total++;
    if (axis.tdata !== '0) begin
      bad++; $display("FAIL rst_tdata: got %h, want 0", axis.tdata);
    end
    total++;
    if (frame_index_out !== 9'd0 || drop_count_out !== 16'd0) begin
      bad++; $display("FAIL rst_counters: index=%0d drops=%0d, want 0 0", frame_index_out, drop_count_out);
    end
    total++;
    if (audio_ready_out !== 1'b1) begin
      bad++; $display("FAIL rst_ready: got %b, want 1", audio_ready_out);
    end
    model_reset();
    rst_in = 1'b1;
    tick();
  endtask

  task automatic test_window_frame();
    int nlast;
    log_q.delete();
    window_en_in   = 1'b1;
    axis.tready    = 1'b1;
    audio_data_in  = fill(1000);
    audio_valid_in = 1'b1;
    tick();
    total++;
    if (axis.tvalid !== 1'b0) begin bad++; $display("FAIL latency_k: tvalid=%b, want 0", axis.tvalid); end
    tick();
    total++;
    if (axis.tvalid !== 1'b0) begin bad++; $display("FAIL latency_k1: tvalid=%b, want 0", axis.tvalid); end
    tick();
    total++;
    if (axis.tvalid !== 1'b1) begin bad++; $display("FAIL latency_k2: tvalid=%b, want 1", axis.tvalid); end
    for (int i = 3; i < N; i++) send(fill(1000));
    drain();
    total++;
    if (log_q.size() != N) begin bad++; $display("FAIL win_count: beats=%0d, want %0d", log_q.size(), N); end
    total++;
    if (log_q[0].d !== '0) begin bad++; $display("FAIL win_beat0: got %h, want 0", log_q[0].d); end
    total++;
    if (log_q[256].d !== w1000) begin bad++; $display("FAIL win_beat256: got %h, want %h", log_q[256].d, w1000); end
    total++;
    if (log_q[511].d !== '0) begin bad++; $display("FAIL win_beat511: got %h, want 0", log_q[511].d); end
    nlast = 0;
    foreach (log_q[i]) if (log_q[i].l) nlast++;
    total++;
    if (nlast != 1 || log_q[511].l !== 1'b1) begin
      bad++; $display("FAIL win_tlast: count=%0d last_on_511=%b, want 1 1", nlast, log_q[511].l);
    end
  endtask

  task automatic test_bypass();
    mic_frame_t s;
    log_q.delete();
    window_en_in = 1'b0;
    s[0] = -16'sd32768;
    s[1] = 16'sd32767;
    s[2] = -16'sd1;
    s[3] = 16'sd0;
    send(s);
    drain();
    total++;
    if (log_q[0].d !== 128'h0000_0000_FFFF_0000_7FFF_0000_8000_0000) begin
      bad++; $display("FAIL bypass_word: got %h, want 0000_0000_ffff_0000_7fff_0000_8000_0000", log_q[0].d);
    end
    total++;
    if (frame_index_out !== 9'd1) begin bad++; $display("FAIL bypass_index: got %0d, want 1", frame_index_out); end
  endtask

  task automatic test_hold();
    int nlast;
    for (int i = 1; i < 200; i++) send(rand_frame());
    audio_data_in = rand_frame();
    axis.tready   = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_in);
      total++;
      if (axis.tvalid !== 1'b1 || audio_ready_out !== 1'b0 || axis.tdata !== sb[0].d) begin
        bad++;
        $display("FAIL hold_stall: tvalid=%b ready=%b tdata=%h, want 1 0 %h", axis.tvalid, audio_ready_out, axis.tdata, sb[0].d);
      end
      total++;
      if (frame_index_out !== 9'd200) begin bad++; $display("FAIL hold_index: got %0d, want 200", frame_index_out); end
      tick();
    end
    axis.tready = 1'b1;
    @(negedge clk_in);
    total++;
    if (drop_count_out !== 16'd5) begin bad++; $display("FAIL hold_drops: got %0d, want 5", drop_count_out); end
    tick();
    for (int i = 201; i < N; i++) send(rand_frame());
    drain();
    nlast = 0;
    foreach (log_q[i]) if (log_q[i].l) nlast++;
    total++;
    if (log_q.size() != N || nlast != 1 || log_q[N-1].l !== 1'b1) begin
      bad++; $display("FAIL hold_frame: beats=%0d tlasts=%0d last=%b, want %0d 1 1", log_q.size(), nlast, log_q[N-1].l, N);
    end
  endtask

  task automatic test_window_toggle();
    logic [15:0]  e16;
    logic [127:0] e300;
    log_q.delete();
    window_en_in = 1'b1;
    for (int i = 0; i < 2 * N; i++) begin
      if (i == 100) window_en_in = 1'b0;
      send(fill(1000));
    end
    drain();
    e16  = 16'((1000 * win[300] + 16384) >>> 15);
    e300 = {4{e16, 16'h0000}};
    total++;
    if (log_q[0].d !== '0) begin bad++; $display("FAIL toggle_a0: got %h, want 0", log_q[0].d); end
    total++;
    if (log_q[300].d !== e300) begin bad++; $display("FAIL toggle_a300: got %h, want %h", log_q[300].d, e300); end
    total++;
    if (log_q[N].d !== w1000) begin bad++; $display("FAIL toggle_b0: got %h, want %h", log_q[N].d, w1000); end
    total++;
    if (log_q[2*N-1].d !== w1000) begin bad++; $display("FAIL toggle_b511: got %h, want %h", log_q[2*N-1].d, w1000); end
  endtask

  task automatic test_reset_mid_frame();
    int nlast;
    window_en_in = 1'b1;
    for (int i = 0; i < 300; i++) send(fill(1000));
    total++;
    if (axis.tvalid !== 1'b1) begin bad++; $display("FAIL midrst_pre: tvalid=%b, want 1", axis.tvalid); end
    #2 rst_in = 1'b0;
    audio_valid_in = 1'b0;
    model_reset();
    #1;
    total++;
    if (axis.tvalid !== 1'b0) begin bad++; $display("FAIL midrst_async: tvalid=%b, want 0", axis.tvalid); end
    total++;
    if (frame_index_out !== 9'd0 || drop_count_out !== 16'd0) begin
      bad++; $display("FAIL midrst_counters: index=%0d drops=%0d, want 0 0", frame_index_out, drop_count_out);
    end
    tick();
    tick();
    rst_in = 1'b1;
    log_q.delete();
    for (int i = 0; i < N; i++) send(fill(1000));
    drain();
    nlast = 0;
    foreach (log_q[i]) if (log_q[i].l) nlast++;
    total++;
    if (log_q[0].d !== '0 || log_q[256].d !== w1000) begin
      bad++; $display("FAIL midrst_index0: beat0=%h beat256=%h, want 0 %h", log_q[0].d, log_q[256].d, w1000);
    end
    total++;
    if (log_q.size() != N || nlast != 1 || log_q[N-1].l !== 1'b1) begin
      bad++; $display("FAIL midrst_tlast: beats=%0d tlasts=%0d last=%b, want %0d 1 1", log_q.size(), nlast, log_q[N-1].l, N);
    end
  endtask

  task automatic test_random();
    int badpos;
    log_q.delete();
    m_acc = 0;
    for (int t = 0; t < 20000 && m_acc < 4 * N; t++) begin
      audio_valid_in = ($urandom_range(0, 9) < 7);
      audio_data_in  = rand_frame();
      window_en_in   = $urandom_range(0, 1);
      axis.tready    = ($urandom_range(0, 9) < 7);
      tick();
    end
    drain();
    total++;
    if (m_acc != 4 * N) begin bad++; $display("FAIL rand_accepts: got %0d, want %0d", m_acc, 4 * N); end
    total++;
    if (drop_count_out !== 16'(m_drop)) begin bad++; $display("FAIL rand_drops: got %0d, want %0d", drop_count_out, m_drop); end
    badpos = 0;
    foreach (log_q[i]) if (log_q[i].l !== ((i % N) == N - 1)) badpos++;
    total++;
    if (log_q.size() != 4 * N || badpos != 0) begin
      bad++; $display("FAIL rand_tlast: beats=%0d misplaced=%0d, want %0d 0", log_q.size(), badpos, 4 * N);
    end
    total++;
    if (frame_index_out !== 9'd0) begin bad++; $display("FAIL rand_index: got %0d, want 0", frame_index_out); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      win[i] = $rtoi(32767.5 * (1.0 - $cos(2.0 * PI * real'(i) / real'(N))) + 0.5) >> 1;
    end
    w1000 = {4{16'd1000, 16'h0000}};
    axis.tready = 1'b1;
    test_reset();
    test_window_frame();
    test_bypass();
    test_hold();
    test_window_toggle();
    test_reset_mid_frame();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
